// File: rtl/warp_icache.sv
// warp_icache: direct-mapped, read-only instruction cache in front of warp_fetch.
// One fetch is handled at a time. A miss refills the whole line from the memory
// side, one 64-bit beat per i_mem_rvalid. i_flush invalidates every line in one
// cycle. A flush that arrives during a refill still lets the refill finish and
// return its data, but the refilled line is left invalid.
module warp_icache #(
  parameter int LINES      = 64,
  parameter int LINE_BEATS = 4,
  parameter int ADDR_W     = 39
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_imem_ren,
  input  logic [ADDR_W-1:0] i_imem_raddr,
  output logic              o_imem_valid,
  output logic [63:0]       o_imem_rdata,
  input  logic              i_flush,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic              i_mem_rvalid,
  input  logic [63:0]       i_mem_rdata
);

  localparam int OFF_W  = $clog2(LINE_BEATS * 8);
  localparam int WORD_W = $clog2(LINE_BEATS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, REQ, FILL, RESP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   beat_q, beat_d;
  logic                poison_q, poison_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic                imem_valid_q, imem_valid_d;
  logic [63:0]         imem_rdata_q, imem_rdata_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

  logic [63:0]         data_mem [LINES*LINE_BEATS];
  logic [TAG_W-1:0]    tag_mem  [LINES];

  logic [WORD_W-1:0]   req_word;
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [63:0]         rd_data;
  logic                hit;
  logic                data_we;
  logic                tag_we;
  logic                unused_addr_bits;

  assign req_word         = addr_q[OFF_W-1:3];
  assign req_idx          = addr_q[OFF_W+IDX_W-1:OFF_W];
  assign req_tag          = addr_q[ADDR_W-1:OFF_W+IDX_W];
  assign unused_addr_bits = ^addr_q[2:0];

  // The requested word is read combinationally for both the hit path and RESP;
  // a flush in the lookup cycle must turn a would-be hit into a miss.
  assign rd_data = data_mem[{req_idx, req_word}];
  assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag) && !i_flush;

  // Next-state, refill bookkeeping and registered-output values.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beat_d       = beat_q;
    poison_d     = poison_q;
    valid_d      = valid_q;
    imem_valid_d = 1'b0;
    imem_rdata_d = imem_rdata_q;
    mem_addr_d   = mem_addr_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_imem_ren) begin
          addr_d  = i_imem_raddr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          imem_valid_d = 1'b1;
          imem_rdata_d = rd_data;
          state_d      = IDLE;
        end else begin
          mem_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
          state_d    = REQ;
        end
      end
      REQ: begin
        if (i_flush) poison_d = 1'b1;
        if (i_mem_ack) begin
          beat_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (i_flush) poison_d = 1'b1;
        if (i_mem_rvalid) begin
          data_we = 1'b1;
          beat_d  = beat_q + WORD_W'(1);
          if (beat_q == WORD_W'(LINE_BEATS - 1)) begin
            tag_we           = 1'b1;
            valid_d[req_idx] = !poison_q;
            state_d          = RESP;
          end
        end
      end
      RESP: begin
        imem_valid_d = 1'b1;
        imem_rdata_d = rd_data;
        poison_d     = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_flush) valid_d = '0;
  end

  assign mem_req_d = (state_d == REQ);

  // State and control registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      beat_q       <= '0;
      poison_q     <= 1'b0;
      valid_q      <= '0;
      imem_valid_q <= 1'b0;
      imem_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      poison_q     <= poison_d;
      valid_q      <= valid_d;
      imem_valid_q <= imem_valid_d;
      imem_rdata_q <= imem_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // Data and tag arrays; no reset, validity lives in valid_q.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && data_we) data_mem[{req_idx, beat_q}] <= i_mem_rdata;
    if (i_rst_n && tag_we)  tag_mem[req_idx] <= req_tag;
  end

  assign o_imem_valid = imem_valid_q;
  assign o_imem_rdata = imem_rdata_q;
  assign o_mem_req    = mem_req_q;
  assign o_mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_warp_icache.sv
// tb_warp_icache: scoreboard bench for warp_icache with a line-level cache model
// and a memory model whose data is a fixed function of the doubleword address.
module tb_warp_icache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ren;
  logic [38:0] raddr;
  logic        imem_valid;
  logic [63:0] imem_rdata;
  logic        flush;
  logic        mem_req;
  logic [38:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  logic [63:0] exp_data_q[$];
  int          exp_cyc_q[$];
  bit          model_valid[64];
  logic [27:0] model_tag[64];

  logic [63:0] mon_data;
  int          mon_cyc;

  warp_icache dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_imem_ren   (ren),
    .i_imem_raddr (raddr),
    .o_imem_valid (imem_valid),
    .o_imem_rdata (imem_rdata),
    .i_flush      (flush),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .i_mem_ack    (mem_ack),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Backing memory contents: a fixed scramble of the doubleword address
  function automatic logic [63:0] mem_word(input logic [38:0] a);
    logic [63:0] w;
    w = 64'h9E37_79B9_7F4A_7C15 * {28'd0, a[38:3]};
    return w ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelFlush();
    for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && imem_valid) begin
      if (exp_data_q.size() == 0) begin
        checkOutput("unexpected valid pulse", 64'd1, 64'd0);
      end else begin
        mon_data = exp_data_q.pop_front();
        checkOutput("rdata", imem_rdata, mon_data);
        if (exp_cyc_q.size() == 0) begin
          checkOutput("valid too early", 64'd1, 64'd0);
        end else begin
          mon_cyc = exp_cyc_q.pop_front();
          checkOutput("valid cycle", 64'(cyc), 64'(mon_cyc));
        end
      end
    end
  end

  task automatic applyFlush();
    @(posedge clk); #1;
    flush = 1'b1;
    modelFlush();
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // One fetch, acting as the memory side too. flush_at: -1 none, 0..3 on that
  // beat, 4 on the ack cycle. abort resets the cache right after beat 1.
  task automatic applyStimulus(input logic [38:0] addr, input int ack_delay, input int gap,
                               input int flush_at, input bit flush_lookup, input bit abort);
    logic [38:0] line;
    int          idx;
    logic [27:0] tag;
    bit          hit;
    int          n;
    int          b;
    bit          aborted;
    line    = (addr / 39'd32) * 39'd32;
    idx     = int'((addr / 39'd32) % 39'd64);
    tag     = 28'(addr / 39'd2048);
    aborted = 1'b0;
    b       = 0;
    exp_data_q.push_back(mem_word(addr));
    @(posedge clk); #1;
    ren   = 1'b1;
    raddr = addr;
    n     = cyc;
    @(posedge clk); #1;
    ren = 1'b0;
    if (flush_lookup) begin
      flush = 1'b1;
      modelFlush();
    end
    hit = model_valid[idx] && (model_tag[idx] == tag);
    if (hit) exp_cyc_q.push_back(n + 2);
    @(posedge clk); #1;
    flush = 1'b0;
    if (hit) begin
      checkOutput("hit issues no refill", 64'(mem_req), 64'd0);
    end else begin
      checkOutput("miss issues refill", 64'(mem_req), 64'd1);
      checkOutput("refill address", 64'(mem_addr), 64'(line));
      for (int d = 0; d < ack_delay; d++) begin
        @(posedge clk); #1;
        checkOutput("req held while unacked", 64'(mem_req), 64'd1);
        checkOutput("addr stable while unacked", 64'(mem_addr), 64'(line));
      end
      mem_ack = 1'b1;
      if (flush_at == 4) begin
        flush = 1'b1;
        modelFlush();
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      flush   = 1'b0;
      checkOutput("req dropped after ack", 64'(mem_req), 64'd0);
      for (int k = 0; k < 4 && !aborted; k++) begin
        repeat (gap) begin
          @(posedge clk); #1;
        end
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(line + 39'(8 * k));
        if (flush_at == k) begin
          flush = 1'b1;
          modelFlush();
        end
        b = cyc;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        flush      = 1'b0;
        if (abort && k == 1) begin
          rst_n = 1'b0;
          exp_data_q.delete();
          exp_cyc_q.delete();
          modelFlush();
          @(posedge clk); #1;
          rst_n = 1'b1;
          checkOutput("reset drops req", 64'(mem_req), 64'd0);
          checkOutput("reset clears valid", 64'(imem_valid), 64'd0);
          checkOutput("reset clears mem_addr", 64'(mem_addr), 64'd0);
          mem_rvalid = 1'b1;
          mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
          repeat (2) begin
            @(posedge clk); #1;
          end
          mem_rvalid = 1'b0;
          aborted    = 1'b1;
        end
      end
      if (!aborted) begin
        exp_cyc_q.push_back(b + 2);
        if (flush_at < 0) begin
          model_valid[idx] = 1'b1;
          model_tag[idx]   = tag;
        end
      end
    end
    for (int t = 0; t < 12 && exp_data_q.size() != 0; t++) @(posedge clk);
    if (exp_data_q.size() != 0) begin
      checkOutput("response timeout", 64'(exp_data_q.size()), 64'd0);
      exp_data_q.delete();
      exp_cyc_q.delete();
    end
    #1;
  endtask

  // Directed scenarios first, then randomized traffic over a few aliasing lines
  initial begin
    logic [38:0] a;
    int          tsel;
    int          fa;
    logic [27:0] tags[3];
    int          idxs[4];
    tags[0] = 28'h080_0000;
    tags[1] = 28'h080_0001;
    tags[2] = 28'h000_0003;
    idxs[0] = 0;
    idxs[1] = 1;
    idxs[2] = 5;
    idxs[3] = 63;
    rst_n = 1'b0; ren = 1'b0; raddr = '0; flush = 1'b0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    modelFlush();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset imem_valid", 64'(imem_valid), 64'd0);
    checkOutput("reset imem_rdata", imem_rdata, 64'd0);
    checkOutput("reset mem_req", 64'(mem_req), 64'd0);
    checkOutput("reset mem_addr", 64'(mem_addr), 64'd0);
    rst_n = 1'b1;

    applyStimulus(39'h40_0000_0008, 0, 0, -1, 1'b0, 1'b0);
    applyStimulus(39'h40_0000_0018, 0, 0, -1, 1'b0, 1'b0);
    applyStimulus(39'h40_0000_0000, 0, 0, -1, 1'b0, 1'b0);
    applyStimulus(39'h40_0000_0800, 1, 0, -1, 1'b0, 1'b0);
    applyStimulus(39'h40_0000_0000, 0, 0, -1, 1'b0, 1'b0);
    applyStimulus(39'h40_0000_1050, 5, 2, -1, 1'b0, 1'b0);
    applyStimulus(39'h40_0000_1048, 0, 0, -1, 1'b0, 1'b0);
    applyFlush();
    applyStimulus(39'h40_0000_1048, 0, 0, -1, 1'b0, 1'b0);
    applyStimulus(39'h40_0000_0110, 0, 1, 2, 1'b0, 1'b0);
    applyStimulus(39'h40_0000_0110, 0, 0, -1, 1'b0, 1'b0);
    applyStimulus(39'h40_0000_0180, 0, 0, 3, 1'b0, 1'b0);
    applyStimulus(39'h40_0000_0188, 0, 0, -1, 1'b0, 1'b0);
    applyStimulus(39'h40_0000_01A0, 2, 0, 4, 1'b0, 1'b0);
    applyStimulus(39'h40_0000_01A8, 0, 0, -1, 1'b0, 1'b0);
    applyStimulus(39'h40_0000_01B0, 0, 0, -1, 1'b1, 1'b0);
    applyStimulus(39'h40_0000_0208, 0, 0, -1, 1'b0, 1'b1);
    applyStimulus(39'h40_0000_0208, 0, 0, -1, 1'b0, 1'b0);
    applyStimulus(39'h40_0000_0218, 0, 0, -1, 1'b0, 1'b0);

    for (int r = 0; r < 60; r++) begin
      tsel = int'($urandom_range(0, 2));
      a    = {tags[tsel], 11'd0} + 39'(idxs[$urandom_range(0, 3)] * 32)
             + 39'($urandom_range(0, 3) * 8);
      fa   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      if ($urandom_range(0, 9) == 0) applyFlush();
      applyStimulus(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), fa,
                    ($urandom_range(0, 9) == 0), 1'b0);
    end

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
